// File: rtl/alu_pkg.sv
// Shared types for the ALU and the sequential multiplier.
package alu_pkg;

  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } ALUOp;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } ALUFlags;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } mul_state_e;

endpackage

// File: rtl/mul_seq_alu.sv
// Shared 16-bit ALU. One adder serves both ADD and SUB: SUB is done by
// inverting s2 and injecting a carry-in.
module ALU
  import alu_pkg::*;
(
  input  ALUOp          op_i,
  input  logic [DW-1:0] s1_i,
  input  logic [DW-1:0] s2_i,
  output logic [DW-1:0] result_o,
  output ALUFlags       flags_o
);

  logic [DW:0]   sum;
  logic [DW-1:0] s2_eff;
  logic          cin;

  // Combinational datapath and flag generation.
  always_comb begin
    cin      = (op_i == ALU_SUB);
    s2_eff   = cin ? ~s2_i : s2_i;
    sum      = {1'b0, s1_i} + {1'b0, s2_eff} + {{DW{1'b0}}, cin};
    result_o = '0;
    flags_o  = '0;
    case (op_i)
      ALU_ADD, ALU_SUB: begin
        result_o      = sum[DW-1:0];
        flags_o.carry = sum[DW];
        flags_o.ovf   = (s1_i[DW-1] == s2_eff[DW-1]) && (sum[DW-1] != s1_i[DW-1]);
      end
      ALU_AND: result_o = s1_i & s2_i;
      ALU_OR:  result_o = s1_i | s2_i;
      default: result_o = '0;
    endcase
    flags_o.zero = (result_o == '0);
    flags_o.neg  = result_o[DW-1];
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-and-add 16x16 unsigned multiplier returning the low
// 16 bits of the product plus an overflow flag for the discarded upper half.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start; product/ovf hold last result
// ST_RUN  | one shift-and-add step per cycle until multiplier empties
// ST_DONE | single-cycle done pulse, then back to ST_IDLE
module mul_seq
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] product,
  output logic          ovf
);

  mul_state_e    state_q;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] mcand_q;
  logic [DW-1:0] mplier_q;
  logic [DW-1:0] mplier_d;
  logic          ovf_q;
  logic          lost_q;
  logic          busy_q;
  logic          done_q;

  logic [DW-1:0] alu_res;
  ALUFlags       alu_flags;
  logic          unused_alu_flags;

  // Accumulate adder; only the carry is consumed.
  ALU u_alu (
    .op_i     (ALU_ADD),
    .s1_i     (acc_q),
    .s2_i     (mcand_q),
    .result_o (alu_res),
    .flags_o  (alu_flags)
  );

  assign unused_alu_flags = &{1'b0, alu_flags.zero, alu_flags.neg, alu_flags.ovf};

  // Post-shift multiplier; its emptiness ends the RUN phase.
  assign mplier_d = mplier_q >> 1;

  // Control FSM with registered status outputs and the shift/accumulate datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      ovf_q    <= 1'b0;
      lost_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            lost_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (mplier_q[0]) begin
            acc_q <= alu_res;
            // lost_q here is the value before this cycle's shift: a bit that
            // fell off mcand only matters if a later multiplier bit uses it.
            ovf_q <= ovf_q | alu_flags.carry | lost_q;
          end
          mcand_q  <= mcand_q << 1;
          lost_q   <= lost_q | mcand_q[DW-1];
          mplier_q <= mplier_d;
          if (mplier_d == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq.
module tb_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  mul_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and check latency, result and post-done behaviour.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] exp_p, input logic exp_o, input int exp_lat);
    int cyc;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_prod"}, {16'd0, product}, {16'd0, exp_p});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_o});
    tick();
    chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    tick();
    chk({tag, "_hold"}, {15'd0, ovf, product}, {15'd0, exp_o, exp_p});
  endtask

  initial begin
    int cyc;
    int seen_done;
    rst = 1'b1; start = 1'b1; a = 16'h0003; b = 16'h0005;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_prod", {16'd0, product}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    start = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run_op("m3x5",    16'h0003, 16'h0005, 16'h000F, 1'b0, 4);
    run_op("mffxff",  16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 17);
    run_op("m100",    16'h0100, 16'h0100, 16'h0000, 1'b1, 10);
    run_op("mb0",     16'h1234, 16'h0000, 16'h0000, 1'b0, 2);
    run_op("mff101",  16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 10);
    run_op("m8000x2", 16'h8000, 16'h0002, 16'h0000, 1'b1, 3);
    run_op("m1x8000", 16'h0001, 16'h8000, 16'h8000, 1'b0, 17);
    run_op("mffffx1", 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 2);
    run_op("m8001x3", 16'h8001, 16'h0003, 16'h8003, 1'b1, 3);

    // Start pulses during RUN must be ignored.
    a = 16'h0002; b = 16'h0003; start = 1'b1;
    tick();
    cyc = 1;
    a = 16'h0007; b = 16'h0007; start = 1'b1;
    tick();
    cyc = 2;
    chk("ign_busy", {31'd0, busy}, 32'd1);
    tick();
    cyc = 3;
    start = 1'b0;
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_prod", {16'd0, product}, 32'd6);
    chk("ign_ovf", {31'd0, ovf}, 32'd0);
    // Start held during DONE must also be ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_done_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("ign_done_busy2", {31'd0, busy}, 32'd0);
    chk("ign_done_prod", {16'd0, product}, 32'd6);

    // Reset in the middle of a long run abandons it.
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_prod", {16'd0, product}, 32'd0);
    chk("mrst_ovf", {31'd0, ovf}, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) seen_done++;
      tick();
    end
    chk("mrst_no_done", seen_done, 0);
    run_op("after_rst", 16'h0003, 16'h0005, 16'h000F, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001: Parameters: none; datapath width is fixed at 16 bits to match the shared ALU.
REQ-002: clk  input  1  single clock; all state updates on its rising edge.
REQ-003: rst  input  1  synchronous, active-high reset.
REQ-004: start  input  1  one-cycle request; samples a and b; honoured only in IDLE.
REQ-005: a  input  16  multiplicand, unsigned.
REQ-006: b  input  16  multiplier, unsigned.
REQ-007: busy  output  1  high while state is RUN or DONE.
REQ-008: done  output  1  one-cycle pulse; product and ovf are valid in that cycle.
REQ-009: product  output  16  low 16 bits of a*b.
REQ-010: ovf  output  1  high iff the full 32-bit a*b is at least 2^16.

Function
REQ-011: States: IDLE, RUN, DONE.
  - IDLE->RUN on start.
  - RUN->DONE when the post-shift multiplier register is zero.
  - DONE->IDLE unconditionally after one cycle.
REQ-012: On start in IDLE, the block loads:
  - mcand <= a; mplier <= b.
  - acc <= 0; ovf_r <= 0; lost <= 0.
REQ-013: Each RUN cycle, if mplier[0]=1, acc <= ALU ADD(acc, mcand); if mplier[0]=0, acc holds.
REQ-014: Each RUN cycle also updates the shift registers:
  - mcand <= mcand<<1; lost <= lost | mcand[15].
  - mplier <= mplier>>1 (logical).
REQ-015: Each RUN cycle where mplier[0]=1, ovf_r <= ovf_r | ALU carry | lost, with lost taken as its pre-update value.
REQ-016: RUN always executes at least one iteration.
  - Iteration count = max(1, position of the highest set bit of b + 1).
  - The maximum is 16.
REQ-017: done asserts in the single DONE cycle; start-to-done latency = iterations + 1 cycles.
REQ-018: product = acc and ovf = ovf_r at all times; both hold their values after DONE until the next accepted start.
REQ-019: start in RUN or DONE is ignored: no operand capture and no effect on the current operation.
REQ-020: start in the DONE cycle is ignored; a new request is accepted only in IDLE.
REQ-021: The ALU is driven with op=ADD, s1=acc, s2=mcand every RUN cycle; only the carry flag is consumed.

Reset
REQ-022: While rst is high at a clock edge, the block goes to IDLE and clears acc, mcand, mplier, ovf_r and lost to 0.
REQ-023: Reset values: busy=0, done=0, product=0, ovf=0.
REQ-024: Reset during RUN or DONE abandons the operation: no done pulse follows, and rst has priority over start.

Structure
REQ-025: The ALUOp and ALUFlags typedefs and the mul_seq state enum shall live in a shared package, alu_pkg, imported by both ALU and mul_seq.
REQ-026: mul_seq shall instantiate exactly one ALU sub-module (module ALU) for the accumulate add.
  - The shifts are plain register logic.
  - No second adder shall be inferred.

Verification
REQ-027: a=3, b=5, start -> 3 RUN cycles; done on cycle 4 after start; product=0x000F, ovf=0.
REQ-028: a=0xFFFF, b=0xFFFF -> 16 RUN cycles; done on cycle 17; product=0x0001, ovf=1.
REQ-029: a=0x0100, b=0x0100 -> product=0x0000, ovf=1 (overflow detected via lost), done on cycle 10.
REQ-030: a=0x1234, b=0 -> one RUN cycle; done on cycle 2; product=0, ovf=0.
REQ-031: start with a=2, b=3, then start with a=7, b=7 on cycles 1 and 2 (during RUN) -> second start ignored; product=6, ovf=0.
REQ-032: rst on cycle 5 of an a=0xFFFF, b=0xFFFF run -> next cycle busy=0, product=0, ovf=0, and no done pulse; a fresh 3x5 then yields 15.
